// File: rtl/msd_cmd_sched.sv
// msd_cmd_sched: closed-page DDR5 command scheduler.
// One request at a time: ACT0/ACT1, RD/WR pair, PRE.
module msd_cmd_sched #(
  parameter int unsigned T_RCD   = 39,
  parameter int unsigned T_RAS   = 76,
  parameter int unsigned T_RTP   = 18,
  parameter int unsigned T_CWD   = 38,
  parameter int unsigned T_BURST = 8,
  parameter int unsigned T_WR    = 72,
  parameter int unsigned T_RP    = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic        cmd_ch,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done,
  output logic        err
);

  localparam int unsigned RD_SUM = T_RCD + T_RTP;
  localparam int unsigned WR_SUM =
    T_RCD + T_CWD + T_BURST + T_WR;
  localparam int unsigned P_RD =
    (T_RAS > RD_SUM) ? T_RAS : RD_SUM;
  localparam int unsigned P_WR =
    (T_RAS > WR_SUM) ? T_RAS : WR_SUM;
  localparam int unsigned P_MAX =
    (P_WR > P_RD) ? P_WR : P_RD;
  localparam int unsigned CW_R =
    $clog2(P_MAX + T_RP + 1);
  localparam int unsigned CW = (CW_R < 10) ? 10 : CW_R;

  localparam logic [CW-1:0] RCD_END = CW'(T_RCD - 1);
  localparam logic [CW-1:0] PRD_END = CW'(P_RD - 1);
  localparam logic [CW-1:0] PWR_END = CW'(P_WR - 1);
  localparam logic [CW-1:0] RRD_END =
    CW'(P_RD + T_RP - 1);
  localparam logic [CW-1:0] RWR_END =
    CW'(P_WR + T_RP - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ACT0 = 4'd1;
  localparam logic [3:0] S_ACT1 = 4'd2;
  localparam logic [3:0] S_WRCD = 4'd3;
  localparam logic [3:0] S_CAS0 = 4'd4;
  localparam logic [3:0] S_CAS1 = 4'd5;
  localparam logic [3:0] S_WPRE = 4'd6;
  localparam logic [3:0] S_PRE  = 4'd7;
  localparam logic [3:0] S_WRP  = 4'd8;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT0 = 3'd1;
  localparam logic [2:0] C_ACT1 = 3'd2;
  localparam logic [2:0] C_RD0  = 3'd3;
  localparam logic [2:0] C_RD1  = 3'd4;
  localparam logic [2:0] C_WR0  = 3'd5;
  localparam logic [2:0] C_WR1  = 3'd6;
  localparam logic [2:0] C_PRE  = 3'd7;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          ch_q, ch_d;
  logic [2:0]    bg_q, bg_d;
  logic [1:0]    ba_q, ba_d;
  logic [15:0]   row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          err_q, err_d;

  logic          accept;
  logic          legal;
  logic [CW-1:0] pre_end;
  logic [CW-1:0] rp_end;
  logic          unused_addr_bits;

  assign unused_addr_bits =
    ^{req_addr[35:34], req_addr[1:0]};

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_op != 2'd3);
  assign pre_end   = wr_q ? PWR_END : PRD_END;
  assign rp_end    = wr_q ? RWR_END : RRD_END;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    ch_d    = ch_q;
    bg_d    = bg_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = accept && !legal;
    // Counter runs per request from ACT0 and saturates.
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept && legal) begin
          state_d = S_ACT0;
          wr_d    = (req_op == 2'd1);
          ch_d    = req_addr[6];
          bg_d    = req_addr[9:7];
          ba_d    = req_addr[11:10];
          row_d   = req_addr[33:18];
          col_d   = {req_addr[17:12], req_addr[5:2]};
        end
      end
      S_ACT0: state_d = S_ACT1;
      S_ACT1: state_d = (T_RCD == 2) ? S_CAS0 : S_WRCD;
      S_WRCD: begin
        if (cnt_q == RCD_END) state_d = S_CAS0;
      end
      S_CAS0: state_d = S_CAS1;
      S_CAS1, S_WPRE: begin
        state_d = (cnt_q == pre_end) ? S_PRE : S_WPRE;
      end
      S_PRE:  state_d = (T_RP == 1) ? S_IDLE : S_WRP;
      S_WRP: begin
        if (cnt_q == rp_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ch_q    <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      ch_q    <= ch_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd = C_NOP;
    case (state_q)
      S_ACT0:  cmd = C_ACT0;
      S_ACT1:  cmd = C_ACT1;
      S_CAS0:  cmd = wr_q ? C_WR0 : C_RD0;
      S_CAS1:  cmd = wr_q ? C_WR1 : C_RD1;
      S_PRE:   cmd = C_PRE;
      default: cmd = C_NOP;
    endcase
  end

  assign cmd_valid = (cmd != C_NOP);
  assign cmd_ch    = cmd_valid & ch_q;
  assign cmd_bg    = cmd_valid ? bg_q  : '0;
  assign cmd_ba    = cmd_valid ? ba_q  : '0;
  assign cmd_row   = cmd_valid ? row_q : '0;
  assign cmd_col   = cmd_valid ? col_q : '0;
  assign done      = (state_q == S_PRE);
  assign err       = err_q;

endmodule
